// File: rtl/bottle_fill_ctrl.sv
// Pill-bottling controller: counts pills per bottle and bottles per batch in
// BCD, gates the pill feeder, and sequences bottle swaps, pause/resume,
// batch-complete hold and abort. Every output is a register.
//
// Handshake: bottle_ready is a level meaning "an empty bottle is in position".
// It is only consulted in SWAP (and on a valid start). Once FILL is entered it
// is ignored until the next SWAP. pill_pulse is a single-cycle event counted
// only while the feeder gate is open. With the gate closed it raises stray.
module bottle_fill_ctrl #(
  parameter int PILL_DIGITS = 2,
  parameter int BOT_DIGITS  = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     conti,
  input  logic                     single,
  input  logic [4*PILL_DIGITS-1:0] pill_tgt,
  input  logic [4*BOT_DIGITS-1:0]  bot_tgt,
  input  logic                     pill_pulse,
  input  logic                     bottle_ready,
  output logic                     gate_open,
  output logic [4*PILL_DIGITS-1:0] pill_cnt,
  output logic [4*BOT_DIGITS-1:0]  bot_cnt,
  output logic                     bottle_done,
  output logic                     all_full,
  output logic                     paused,
  output logic                     cfg_err,
  output logic                     stray
);

  localparam int PW = 4 * PILL_DIGITS;
  localparam int BW = 4 * BOT_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWAP  = 3'd1,
    S_FILL  = 3'd2,
    S_PAUSE = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pill_tgt_q, pill_tgt_d;
  logic [BW-1:0]   bot_tgt_q, bot_tgt_d;
  logic [PW-1:0]   pill_cnt_d, pill_inc;
  logic [BW-1:0]   bot_cnt_d, bot_inc;
  logic            conti_q, conti_rise;
  logic            gate_d, done_d, full_d, paused_d, cfg_err_d, stray_d;
  logic            tgt_ok;

  // BCD ripple increment: a digit at 9 wraps to 0 and carries into the next.
  function automatic logic [PW-1:0] pill_bcd_inc(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bot_bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < BOT_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A target is usable only if nonzero and every nibble is a decimal digit.
  function automatic logic pill_tgt_valid(input logic [PW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic bot_tgt_valid(input logic [BW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < BOT_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign pill_inc   = pill_bcd_inc(pill_cnt);
  assign bot_inc    = bot_bcd_inc(bot_cnt);
  assign tgt_ok     = pill_tgt_valid(pill_tgt) && bot_tgt_valid(bot_tgt);
  // Held-high conti gives a single resume: only a 0->1 transition acts.
  assign conti_rise = conti & ~conti_q;

  // Next-state, counter and output decode; stop overrides every transition.
  always_comb begin
    state_d    = state_q;
    pill_tgt_d = pill_tgt_q;
    bot_tgt_d  = bot_tgt_q;
    pill_cnt_d = pill_cnt;
    bot_cnt_d  = bot_cnt;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    stray_d    = pill_pulse & ~gate_open;

    if (stop) begin
      state_d    = S_IDLE;
      pill_cnt_d = '0;
      bot_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!tgt_ok) begin
              cfg_err_d = 1'b1;
            end else begin
              pill_tgt_d = pill_tgt;
              bot_tgt_d  = bot_tgt;
              pill_cnt_d = '0;
              bot_cnt_d  = '0;
              state_d    = bottle_ready ? S_FILL : S_SWAP;
            end
          end
        end
        S_SWAP: begin
          if (bottle_ready) state_d = S_FILL;
        end
        S_FILL: begin
          if (pill_pulse) begin
            if (pill_inc == pill_tgt_q) begin
              pill_cnt_d = '0;
              bot_cnt_d  = bot_inc;
              done_d     = 1'b1;
              if (bot_inc == bot_tgt_q) state_d = S_FULL;
              else if (single)          state_d = S_PAUSE;
              else                      state_d = S_SWAP;
            end else begin
              pill_cnt_d = pill_inc;
            end
          end
        end
        S_PAUSE: begin
          if (conti_rise) state_d = S_SWAP;
        end
        S_FULL: begin
          if (conti_rise) begin
            bot_cnt_d = '0;
            state_d   = S_SWAP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    gate_d   = (state_d == S_FILL);
    full_d   = (state_d == S_FULL);
    paused_d = (state_d == S_PAUSE);
  end

  // State, latched targets, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pill_tgt_q  <= '0;
      bot_tgt_q   <= '0;
      pill_cnt    <= '0;
      bot_cnt     <= '0;
      conti_q     <= 1'b0;
      gate_open   <= 1'b0;
      bottle_done <= 1'b0;
      all_full    <= 1'b0;
      paused      <= 1'b0;
      cfg_err     <= 1'b0;
      stray       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pill_tgt_q  <= pill_tgt_d;
      bot_tgt_q   <= bot_tgt_d;
      pill_cnt    <= pill_cnt_d;
      bot_cnt     <= bot_cnt_d;
      conti_q     <= conti;
      gate_open   <= gate_d;
      bottle_done <= done_d;
      all_full    <= full_d;
      paused      <= paused_d;
      cfg_err     <= cfg_err_d;
      stray       <= stray_d;
    end
  end

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Bench for bottle_fill_ctrl: a per-cycle vector table for the short
// sequences plus hand-written runs for long fills, stray pulses, abort/reset
// and a 3-digit carry configuration.
module tb_bottle_fill_ctrl;

  logic CLK = 1'b0;
  logic RST;

  // 2-digit / 2-digit instance
  logic       start, stop, conti, single, pill_pulse, bottle_ready;
  logic [7:0] pill_tgt, bot_tgt;
  logic       gate_open, bottle_done, all_full, paused, cfg_err, stray;
  logic [7:0] pill_cnt, bot_cnt;

  // 3-digit / 1-digit instance
  logic        start3, stop3, conti3, single3, pulse3, ready3;
  logic [11:0] pill_tgt3;
  logic [3:0]  bot_tgt3;
  logic        gate3, done3, full3, paused3, cfg3, stray3;
  logic [11:0] pill_cnt3;
  logic [3:0]  bot_cnt3;

  int checks   = 0;
  int failures = 0;

  bottle_fill_ctrl #(.PILL_DIGITS(2), .BOT_DIGITS(2)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .conti(conti),
    .single(single), .pill_tgt(pill_tgt), .bot_tgt(bot_tgt),
    .pill_pulse(pill_pulse), .bottle_ready(bottle_ready),
    .gate_open(gate_open), .pill_cnt(pill_cnt), .bot_cnt(bot_cnt),
    .bottle_done(bottle_done), .all_full(all_full), .paused(paused),
    .cfg_err(cfg_err), .stray(stray)
  );

  bottle_fill_ctrl #(.PILL_DIGITS(3), .BOT_DIGITS(1)) u_dut3 (
    .CLK(CLK), .RST(RST), .start(start3), .stop(stop3), .conti(conti3),
    .single(single3), .pill_tgt(pill_tgt3), .bot_tgt(bot_tgt3),
    .pill_pulse(pulse3), .bottle_ready(ready3),
    .gate_open(gate3), .pill_cnt(pill_cnt3), .bot_cnt(bot_cnt3),
    .bottle_done(done3), .all_full(full3), .paused(paused3),
    .cfg_err(cfg3), .stray(stray3)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       stop;
    logic       conti;
    logic       single;
    logic [7:0] ptgt;
    logic [7:0] btgt;
    logic       pulse;
    logic       br;
    logic [21:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic logic [21:0] ex(input logic g, input logic [7:0] pc,
                                     input logic [7:0] bc, input logic d,
                                     input logic f, input logic p,
                                     input logic c, input logic s);
    return {g, pc, bc, d, f, p, c, s};
  endfunction

  function automatic vec_t mkv(input logic s, input logic st, input logic co,
                               input logic si, input logic [7:0] pt,
                               input logic [7:0] bt, input logic pu,
                               input logic br, input logic [21:0] e);
    vec_t v;
    v.start = s; v.stop = st; v.conti = co; v.single = si;
    v.ptgt = pt; v.btgt = bt; v.pulse = pu; v.br = br; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] bcd2(input int n);
    logic [3:0] hi, lo;
    hi = 4'((n / 10) % 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  function automatic logic [11:0] bcd3(input int n);
    logic [3:0] h, t, u;
    h = 4'((n / 100) % 10);
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {h, t, u};
  endfunction

  function automatic logic [21:0] out1();
    return {gate_open, pill_cnt, bot_cnt, bottle_done, all_full, paused,
            cfg_err, stray};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    start = 0; stop = 0; conti = 0; single = 0; pill_pulse = 0;
    bottle_ready = 0;
    start3 = 0; stop3 = 0; conti3 = 0; single3 = 0; pulse3 = 0; ready3 = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  task automatic start_batch(input logic [7:0] pt, input logic [7:0] bt,
                             input logic si);
    pill_tgt = pt; bot_tgt = bt; single = si; bottle_ready = 1;
    start = 1; pill_pulse = 0;
    tick();
    start = 0;
  endtask

  task automatic pulses(input int n);
    pill_pulse = 1;
    for (int i = 0; i < n; i++) tick();
    pill_pulse = 0;
  endtask

  // Fill one 9-pill bottle, then 7 pills into the second.
  task automatic fill_to_07_01(input string tag);
    start_batch(8'h09, 8'h03, 1'b0);
    pulses(9);
    tick();
    pulses(7);
    check({tag, "_at_07_01"}, {gate_open, pill_cnt, bot_cnt},
          {1'b1, 8'h07, 8'h01});
  endtask

  initial begin
    pill_tgt = 8'h00; bot_tgt = 8'h00;
    pill_tgt3 = 12'h000; bot_tgt3 = 4'h0;
    do_reset();
    check("reset_out", out1(), 22'd0);
    check("reset_out3", {gate3, pill_cnt3, bot_cnt3, done3, full3, paused3, cfg3, stray3}, 22'd0);

    // start/stop/conti/single/ptgt/btgt/pulse/br -> gate,pc,bc,done,full,paused,cfg,stray
    vecs[0]  = mkv(0,0,0,0,8'h00,8'h00,0,0, ex(0,8'h00,8'h00,0,0,0,0,0));
    vecs[1]  = mkv(1,0,0,0,8'h00,8'h03,0,0, ex(0,8'h00,8'h00,0,0,0,1,0));
    vecs[2]  = mkv(0,0,0,0,8'h00,8'h03,0,0, ex(0,8'h00,8'h00,0,0,0,0,0));
    vecs[3]  = mkv(1,0,0,0,8'h1A,8'h03,0,0, ex(0,8'h00,8'h00,0,0,0,1,0));
    vecs[4]  = mkv(1,0,0,0,8'h05,8'h0A,0,0, ex(0,8'h00,8'h00,0,0,0,1,0));
    vecs[5]  = mkv(1,1,0,0,8'h00,8'h03,0,0, ex(0,8'h00,8'h00,0,0,0,0,0));
    vecs[6]  = mkv(0,0,0,0,8'h00,8'h03,1,0, ex(0,8'h00,8'h00,0,0,0,0,1));
    vecs[7]  = mkv(1,0,0,1,8'h05,8'h02,0,1, ex(1,8'h00,8'h00,0,0,0,0,0));
    vecs[8]  = mkv(0,0,0,1,8'h02,8'h01,1,1, ex(1,8'h01,8'h00,0,0,0,0,0));
    vecs[9]  = mkv(0,0,0,1,8'h05,8'h02,1,1, ex(1,8'h02,8'h00,0,0,0,0,0));
    vecs[10] = mkv(0,0,0,1,8'h05,8'h02,1,1, ex(1,8'h03,8'h00,0,0,0,0,0));
    vecs[11] = mkv(0,0,0,1,8'h05,8'h02,1,1, ex(1,8'h04,8'h00,0,0,0,0,0));
    vecs[12] = mkv(0,0,0,1,8'h05,8'h02,1,1, ex(0,8'h00,8'h01,1,0,1,0,0));
    vecs[13] = mkv(0,0,1,1,8'h05,8'h02,1,0, ex(0,8'h00,8'h01,0,0,0,0,1));
    vecs[14] = mkv(0,0,1,1,8'h05,8'h02,0,1, ex(1,8'h00,8'h01,0,0,0,0,0));
    vecs[15] = mkv(0,0,1,1,8'h05,8'h02,1,1, ex(1,8'h01,8'h01,0,0,0,0,0));
    vecs[16] = mkv(0,0,1,1,8'h05,8'h02,1,1, ex(1,8'h02,8'h01,0,0,0,0,0));
    vecs[17] = mkv(0,0,1,1,8'h05,8'h02,1,1, ex(1,8'h03,8'h01,0,0,0,0,0));
    vecs[18] = mkv(0,0,1,1,8'h05,8'h02,1,1, ex(1,8'h04,8'h01,0,0,0,0,0));
    vecs[19] = mkv(0,0,1,1,8'h05,8'h02,1,1, ex(0,8'h00,8'h02,1,1,0,0,0));
    vecs[20] = mkv(0,0,1,1,8'h05,8'h02,0,1, ex(0,8'h00,8'h02,0,1,0,0,0));
    vecs[21] = mkv(0,0,0,1,8'h05,8'h02,0,1, ex(0,8'h00,8'h02,0,1,0,0,0));
    vecs[22] = mkv(0,0,1,1,8'h05,8'h02,0,1, ex(0,8'h00,8'h00,0,0,0,0,0));
    vecs[23] = mkv(0,0,1,1,8'h05,8'h02,0,1, ex(1,8'h00,8'h00,0,0,0,0,0));
    vecs[24] = mkv(0,0,0,1,8'h05,8'h02,1,1, ex(1,8'h01,8'h00,0,0,0,0,0));
    vecs[25] = mkv(0,1,0,1,8'h05,8'h02,0,1, ex(0,8'h00,8'h00,0,0,0,0,0));
    vecs[26] = mkv(0,0,0,0,8'h05,8'h02,0,1, ex(0,8'h00,8'h00,0,0,0,0,0));

    for (int i = 0; i < NV; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; conti = vecs[i].conti;
      single = vecs[i].single; pill_tgt = vecs[i].ptgt;
      bot_tgt = vecs[i].btgt; pill_pulse = vecs[i].pulse;
      bottle_ready = vecs[i].br;
      tick();
      check($sformatf("vec%0d", i), out1(), vecs[i].exp);
    end

    // Continuous run: 12 pills x 3 bottles, modelled cycle by cycle.
    begin
      int n, b, done_seen;
      logic mfill, mfull, prev_gate, e_done, e_stray;
      do_reset();
      start_batch(8'h12, 8'h03, 1'b0);
      check("cont_start_gate", gate_open, 1'b1);
      n = 0; b = 0; done_seen = 0; mfill = 1; mfull = 0; prev_gate = 1;
      pill_pulse = 1;
      for (int c = 0; c < 60; c++) begin
        tick();
        e_stray = !prev_gate;
        e_done  = 0;
        if (mfill) begin
          n++;
          if (n == 12) begin
            n = 0; b++; e_done = 1; mfill = 0;
            if (b == 3) mfull = 1;
          end
        end else begin
          mfill = 1;
        end
        if (bottle_done) done_seen++;
        check($sformatf("cont_c%0d", c),
              {gate_open, pill_cnt, bot_cnt, bottle_done, all_full, stray},
              {mfill, bcd2(n), bcd2(b), e_done, mfull, e_stray});
        prev_gate = mfill;
        if (mfull) break;
      end
      pill_pulse = 0;
      check("cont_final", {all_full, bot_cnt, gate_open}, {1'b1, 8'h03, 1'b0});
      check("cont_done_count", done_seen, 3);
    end

    // No bottle after completion: gate stays shut and every pulse is stray.
    do_reset();
    start_batch(8'h02, 8'h03, 1'b0);
    pill_pulse = 1;
    tick();
    bottle_ready = 0;
    tick();
    check("swap_done", {bottle_done, pill_cnt, bot_cnt, gate_open},
          {1'b1, 8'h00, 8'h01, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("stray_c%0d", i), {gate_open, stray, pill_cnt},
            {1'b0, 1'b1, 8'h00});
    end
    pill_pulse = 0;
    bottle_ready = 1;
    tick();
    check("ready_reopens", {gate_open, stray}, {1'b1, 1'b0});

    // Abort mid-bottle with stop, then with RST.
    do_reset();
    fill_to_07_01("stop");
    stop = 1;
    tick();
    stop = 0;
    check("stop_clears", out1(), 22'd0);
    tick();
    check("stop_stays_idle", gate_open, 1'b0);
    fill_to_07_01("rst");
    RST = 1;
    tick();
    RST = 0;
    check("rst_clears", out1(), 22'd0);

    // stop with a conti edge while paused: stop wins.
    do_reset();
    start_batch(8'h01, 8'h03, 1'b1);
    pulses(1);
    check("pause_entered", {paused, bot_cnt, gate_open}, {1'b1, 8'h01, 1'b0});
    stop = 1; conti = 1;
    tick();
    stop = 0; conti = 0;
    check("stop_vs_conti", {paused, bot_cnt, gate_open}, {1'b0, 8'h00, 1'b0});
    tick();
    check("stop_vs_conti_idle", gate_open, 1'b0);

    // 3-digit pill counter through 099 -> 100.
    do_reset();
    pill_tgt3 = 12'h100; bot_tgt3 = 4'h1; ready3 = 1; start3 = 1;
    tick();
    start3 = 0;
    check("d3_start_gate", gate3, 1'b1);
    pulse3 = 1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n < 100)
        check($sformatf("d3_n%0d", n), {gate3, pill_cnt3, bot_cnt3, done3, full3},
              {1'b1, bcd3(n), 4'h0, 1'b0, 1'b0});
      else
        check("d3_complete", {gate3, pill_cnt3, bot_cnt3, done3, full3},
              {1'b0, 12'h000, 4'h1, 1'b1, 1'b1});
    end
    pulse3 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
